write_back_stage: RTL and testbench

- Consumer end of the EX/MEM→WB pipeline buffer; final pipeline stage.
- Selects the write-back value from the four buffered data sources using the buffered selector.
- Commits the value into the 8-entry architectural register file; provides two read ports for decode.
- Publishes a registered record of the last committed write (forwarding) and a saturating retire counter.

---
 rtl/write_back_stage.sv | 92 +++++++++
 tb/tb_write_back_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// Final pipeline stage: write-back source mux, 8-entry register file, last-commit record, retire counter.
// Define WB_READ_BYPASS_EN to forward a same-cycle commit straight to a matching read port.
module write_back_stage #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned REG_COUNT   = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_WIDTH-1:0]  i_ex_result,
  input  logic [DATA_WIDTH-1:0]  i_memory_data,
  input  logic [DATA_WIDTH-1:0]  i_immediate,
  input  logic [DATA_WIDTH-1:0]  i_port,
  input  logic [1:0]             i_wb_selector,
  input  logic                   i_write_back,
  input  logic [ADDR_WIDTH-1:0]  i_write_addr,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr_a,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr_b,
  output logic [DATA_WIDTH-1:0]  o_read_data_a,
  output logic [DATA_WIDTH-1:0]  o_read_data_b,
  output logic [DATA_WIDTH-1:0]  o_wb_data,
  output logic                   o_last_wb_valid,
  output logic [ADDR_WIDTH-1:0]  o_last_wb_addr,
  output logic [DATA_WIDTH-1:0]  o_last_wb_data,
  output logic [COUNT_WIDTH-1:0] o_retire_count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] regfile [REG_COUNT];

  // Source select; independent of the commit enable.
  always_comb begin
    o_wb_data = i_ex_result;
    case (i_wb_selector)
      2'b00:   o_wb_data = i_ex_result;
      2'b01:   o_wb_data = i_memory_data;
      2'b10:   o_wb_data = i_immediate;
      default: o_wb_data = i_port;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regfile[i] <= '0;
      end
    end else if (i_write_back) begin
      regfile[i_write_addr] <= o_wb_data;
    end
  end

  // Last-commit record: valid follows the enable every cycle, payload holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_last_wb_valid <= 1'b0;
      o_last_wb_addr  <= '0;
      o_last_wb_data  <= '0;
    end else begin
      o_last_wb_valid <= i_write_back;
      if (i_write_back) begin
        o_last_wb_addr <= i_write_addr;
        o_last_wb_data <= o_wb_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_retire_count <= '0;
    end else if (i_write_back && (o_retire_count != COUNT_MAX)) begin
      o_retire_count <= o_retire_count + COUNT_WIDTH'(1);
    end
  end

`ifdef WB_READ_BYPASS_EN
  logic bypass_a;
  logic bypass_b;

  // Write-through to readers of the register being committed this cycle.
  assign bypass_a = !i_reset && i_write_back && (i_read_addr_a == i_write_addr);
  assign bypass_b = !i_reset && i_write_back && (i_read_addr_b == i_write_addr);

  assign o_read_data_a = bypass_a ? o_wb_data : regfile[i_read_addr_a];
  assign o_read_data_b = bypass_b ? o_wb_data : regfile[i_read_addr_b];
`else
  assign o_read_data_a = regfile[i_read_addr_a];
  assign o_read_data_b = regfile[i_read_addr_b];
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed vector table, hand-written corner sequences, random run vs reference model.
// A second instance with a 4-bit retire counter exercises saturation.
module tb_write_back_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [1:0]    sel;
  logic [DW-1:0] ex, mem, imm, port;
  logic [AW-1:0] waddr, ra, rb;

  logic [DW-1:0] rda, rdb, wbd, ld;
  logic          lv;
  logic [AW-1:0] la;
  logic [15:0]   cnt;

  logic [DW-1:0] rda_s, rdb_s, wbd_s, ld_s;
  logic          lv_s;
  logic [AW-1:0] la_s;
  logic [3:0]    cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  write_back_stage #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .REG_COUNT(8), .COUNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_ex_result(ex), .i_memory_data(mem), .i_immediate(imm),
    .i_port(port), .i_wb_selector(sel), .i_write_back(we), .i_write_addr(waddr),
    .i_read_addr_a(ra), .i_read_addr_b(rb), .o_read_data_a(rda), .o_read_data_b(rdb),
    .o_wb_data(wbd), .o_last_wb_valid(lv), .o_last_wb_addr(la), .o_last_wb_data(ld),
    .o_retire_count(cnt)
  );

  write_back_stage #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .REG_COUNT(8), .COUNT_WIDTH(4)) dut_sat (
    .i_clk(clk), .i_reset(reset), .i_ex_result(ex), .i_memory_data(mem), .i_immediate(imm),
    .i_port(port), .i_wb_selector(sel), .i_write_back(we), .i_write_addr(waddr),
    .i_read_addr_a(ra), .i_read_addr_b(rb), .o_read_data_a(rda_s), .o_read_data_b(rdb_s),
    .o_wb_data(wbd_s), .o_last_wb_valid(lv_s), .o_last_wb_addr(la_s), .o_last_wb_data(ld_s),
    .o_retire_count(cnt_s)
  );

  // Reference model state
  logic [DW-1:0] m_rf [8];
  int            m_cnt;
  int            m_cnt_s;
  logic          m_lv;
  logic [AW-1:0] m_la;
  logic [DW-1:0] m_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_mux();
    logic [DW-1:0] src [4];
    src[0] = ex; src[1] = mem; src[2] = imm; src[3] = port;
    return src[sel];
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
`ifdef WB_READ_BYPASS_EN
    if (!reset && we && (a == waddr)) return m_mux();
`endif
    return m_rf[a];
  endfunction

  function automatic int sat15(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic m_update();
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_cnt = 0; m_cnt_s = 0; m_lv = 1'b0; m_la = '0; m_ld = '0;
    end else begin
      m_lv = we;
      if (we) begin
        m_rf[waddr] = m_mux();
        m_la = waddr;
        m_ld = m_mux();
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic check_model();
    chk("rnd_read_a", 32'(rda), 32'(m_read(ra)));
    chk("rnd_read_b", 32'(rdb), 32'(m_read(rb)));
    chk("rnd_wb_data", 32'(wbd), 32'(m_mux()));
    chk("rnd_last_valid", 32'(lv), 32'(m_lv));
    chk("rnd_last_addr", 32'(la), 32'(m_la));
    chk("rnd_last_data", 32'(ld), 32'(m_ld));
    chk("rnd_count", 32'(cnt), 32'(m_cnt));
    chk("rnd_count_sat", 32'(cnt_s), 32'(m_cnt_s));
  endtask

  typedef struct {
    logic          rst;
    logic          we;
    logic [1:0]    sel;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ex;
    logic [DW-1:0] mem;
    logic [DW-1:0] imm;
    logic [DW-1:0] port;
    logic [DW-1:0] e_ra;
    logic [DW-1:0] e_rb;
    logic [DW-1:0] e_wb;
    logic          e_lv;
    logic [AW-1:0] e_la;
    logic [DW-1:0] e_ld;
    int            e_cnt;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Expectations are observed one edge after the vector is applied, inputs still held.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000, 0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 3'd3, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b1, 3'd3, 16'h1234, 1};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 3'd3, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0, 3'd0, 16'h0000, 0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 3'd3, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0, 3'd0, 16'h0000, 0};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 3'd1, 3'd1, 3'd2, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h0000, 16'h1111, 1'b1, 3'd1, 16'h1111, 1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 3'd2, 3'd1, 3'd2, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h2222, 16'h2222, 1'b1, 3'd2, 16'h2222, 2};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 3'd3, 3'd3, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h3333, 16'h0000, 16'h3333, 1'b1, 3'd3, 16'h3333, 3};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 3'd4, 3'd3, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 16'h4444, 1'b1, 3'd4, 16'h4444, 4};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 3'd5, 3'd5, 3'd4, 16'hBEEF, 16'h2222, 16'h3333, 16'h4444, 16'h0000, 16'h4444, 16'hBEEF, 1'b0, 3'd4, 16'h4444, 4};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 3'd2, 3'd2, 3'd1, 16'h7777, 16'h2222, 16'h3333, 16'h4444, 16'h0000, 16'h0000, 16'h7777, 1'b0, 3'd0, 16'h0000, 0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 3'd2, 3'd2, 3'd1, 16'h7777, 16'h2222, 16'h3333, 16'h4444, 16'h7777, 16'h0000, 16'h7777, 1'b1, 3'd2, 16'h7777, 1};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 3'd2, 3'd2, 3'd1, 16'h7777, 16'h2222, 16'h3333, 16'h4444, 16'h3333, 16'h0000, 16'h3333, 1'b1, 3'd2, 16'h3333, 2};
    vecs[12] = '{1'b0, 1'b1, 2'd3, 3'd0, 3'd0, 3'd2, 16'h7777, 16'h2222, 16'h3333, 16'h4444, 16'h4444, 16'h3333, 16'h4444, 1'b1, 3'd0, 16'h4444, 3};

    reset = 1'b1; we = 1'b0; sel = 2'd0; waddr = '0; ra = '0; rb = '0;
    ex = '0; mem = '0; imm = '0; port = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_cnt = 0; m_cnt_s = 0; m_lv = 1'b0; m_la = '0; m_ld = '0;

    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; we = vecs[i].we; sel = vecs[i].sel; waddr = vecs[i].wa;
      ra = vecs[i].ra; rb = vecs[i].rb; ex = vecs[i].ex; mem = vecs[i].mem;
      imm = vecs[i].imm; port = vecs[i].port;
      tick();
      chk($sformatf("vec%0d_read_a", i), 32'(rda), 32'(vecs[i].e_ra));
      chk($sformatf("vec%0d_read_b", i), 32'(rdb), 32'(vecs[i].e_rb));
      chk($sformatf("vec%0d_wb_data", i), 32'(wbd), 32'(vecs[i].e_wb));
      chk($sformatf("vec%0d_last_valid", i), 32'(lv), 32'(vecs[i].e_lv));
      chk($sformatf("vec%0d_last_addr", i), 32'(la), 32'(vecs[i].e_la));
      chk($sformatf("vec%0d_last_data", i), 32'(ld), 32'(vecs[i].e_ld));
      chk($sformatf("vec%0d_count", i), 32'(cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_count_sat", i), 32'(cnt_s), 32'(sat15(vecs[i].e_cnt)));
    end

    // Same-cycle read of the write target, then reset suppressing the bypass.
    reset = 1'b1; we = 1'b0; tick();
    reset = 1'b0; we = 1'b1; sel = 2'd0; waddr = 3'd6; ex = 16'hA5A5; ra = 3'd6; rb = 3'd6;
    @(negedge clk);
`ifdef WB_READ_BYPASS_EN
    chk("byp_same_cycle_a", 32'(rda), 32'h0000A5A5);
    chk("byp_same_cycle_b", 32'(rdb), 32'h0000A5A5);
`else
    chk("byp_same_cycle_a", 32'(rda), 32'h00000000);
    chk("byp_same_cycle_b", 32'(rdb), 32'h00000000);
`endif
    tick();
    we = 1'b0;
    chk("byp_next_cycle", 32'(rda), 32'h0000A5A5);
    reset = 1'b1; we = 1'b1; ex = 16'h1234;
    @(negedge clk);
    chk("byp_reset_suppress", 32'(rda), 32'h0000A5A5);
    tick();
    chk("byp_after_reset", 32'(rda), 32'h00000000);

    // Saturation: 17 consecutive commits.
    reset = 1'b0; we = 1'b1; sel = 2'd0;
    for (int k = 1; k <= 17; k++) begin
      ex = 16'(k * 3); waddr = 3'(k);
      tick();
      chk($sformatf("sat_count4_k%0d", k), 32'(cnt_s), 32'(sat15(k)));
      chk($sformatf("sat_count16_k%0d", k), 32'(cnt), 32'(k));
    end

    // Random run against the reference model.
    reset = 1'b1; we = 1'b0; tick();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      we    = ($urandom_range(0, 3) != 0);
      sel   = 2'($urandom);
      waddr = 3'($urandom);
      ra    = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom);
      rb    = 3'($urandom);
      ex    = 16'($urandom); mem = 16'($urandom);
      imm   = 16'($urandom); port = 16'($urandom);
      @(negedge clk);
      check_model();
      tick();
    end
    we = 1'b0; reset = 1'b0;
    @(negedge clk);
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
